// File: rtl/mmio_display_port.sv
// CPU data-bus peripheral: LED and display registers, switch readback,
// and the multiplexed 8-digit seven-segment scan engine.
module mmio_display_port #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_,
    input  logic [7:0]  io_addr,
    input  logic        io_write,
    input  logic        io_read,
    input  logic [1:0]  siz,
    input  logic        SE_s,
    input  logic [31:0] io_wdata,
    output logic [31:0] io_rdata,
    input  logic [2:0]  switch,
    output logic [16:0] Led,
    output logic [7:0]  AN,
    output logic [7:0]  Seg
);

    localparam int unsigned DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [16:0]   led_q, led_d;
    logic [31:0]   disp_q, disp_d;
    logic [15:0]   ctrl_q, ctrl_d;
    logic [2:0]    sw1_q, sw2_q;
    logic [31:0]   rdata_q, rdata_d;
    logic [DW-1:0] div_q, div_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    an_q, an_d;
    logic [7:0]    seg_q, seg_d;

    logic [3:0]  be;
    logic [31:0] wd, bm, rd_word;
    logic [7:0]  rb;
    logic [15:0] rh;
    logic [3:0]  nib;
    logic [6:0]  glyph;
    logic        sel_led, sel_disp, sel_ctrl, sel_sw;

    assign sel_led  = io_addr[7:2] == 6'd0;
    assign sel_disp = io_addr[7:2] == 6'd1;
    assign sel_ctrl = io_addr[7:2] == 6'd2;
    assign sel_sw   = io_addr[7:2] == 6'd3;

    function automatic logic [6:0] hex7seg(input logic [3:0] n);
        case (n)
            4'h0: hex7seg = 7'h3F;
            4'h1: hex7seg = 7'h06;
            4'h2: hex7seg = 7'h5B;
            4'h3: hex7seg = 7'h4F;
            4'h4: hex7seg = 7'h66;
            4'h5: hex7seg = 7'h6D;
            4'h6: hex7seg = 7'h7D;
            4'h7: hex7seg = 7'h07;
            4'h8: hex7seg = 7'h7F;
            4'h9: hex7seg = 7'h6F;
            4'hA: hex7seg = 7'h77;
            4'hB: hex7seg = 7'h7C;
            4'hC: hex7seg = 7'h39;
            4'hD: hex7seg = 7'h5E;
            4'hE: hex7seg = 7'h79;
            default: hex7seg = 7'h71;
        endcase
    endfunction

    // Store lane enables and store data replicated onto every lane.
    always_comb begin
        be = 4'b1111;
        wd = io_wdata;
        case (siz)
            2'd0: begin
                be = 4'b0001 << io_addr[1:0];
                wd = {4{io_wdata[7:0]}};
            end
            2'd1: begin
                be = io_addr[1] ? 4'b1100 : 4'b0011;
                wd = {2{io_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = io_wdata;
            end
        endcase
        bm = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    end

    // Register next-state; only physically present bits take the merge.
    always_comb begin
        led_d  = led_q;
        disp_d = disp_q;
        ctrl_d = ctrl_q;
        if (io_write && sel_led)
            led_d = (led_q & ~bm[16:0]) | (wd[16:0] & bm[16:0]);
        if (io_write && sel_disp)
            disp_d = (disp_q & ~bm) | (wd & bm);
        if (io_write && sel_ctrl)
            ctrl_d = (ctrl_q & ~bm[15:0]) | (wd[15:0] & bm[15:0]);
    end

    // Load path: pre-write register value, lane select, extension.
    always_comb begin
        rd_word = 32'd0;
        if (sel_led)  rd_word = {15'd0, led_q};
        if (sel_disp) rd_word = disp_q;
        if (sel_ctrl) rd_word = {16'd0, ctrl_q};
        if (sel_sw)   rd_word = {29'd0, sw2_q};
        rb = 8'(rd_word >> {io_addr[1:0], 3'b000});
        rh = io_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (siz)
            2'd0:    rdata_d = {{24{SE_s & rb[7]}}, rb};
            2'd1:    rdata_d = {{16{SE_s & rh[15]}}, rh};
            default: rdata_d = rd_word;
        endcase
        if (!io_read)
            rdata_d = rdata_q;
    end

    // Scan divider, digit index and the next anode/segment pattern.
    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end
        nib   = disp_q[{idx_q, 2'b00} +: 4];
        glyph = hex7seg(nib);
        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (ctrl_q[idx_q]) begin
            an_d  = ~(8'd1 << idx_q);
            seg_d = ~{ctrl_q[8 + {1'b0, idx_q}], glyph};
        end
    end

    // All state, async active-low reset.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            led_q   <= '0;
            disp_q  <= '0;
            ctrl_q  <= 16'h00FF;
            sw1_q   <= '0;
            sw2_q   <= '0;
            rdata_q <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            an_q    <= 8'hFE;
            seg_q   <= 8'hC0;
        end else begin
            led_q   <= led_d;
            disp_q  <= disp_d;
            ctrl_q  <= ctrl_d;
            sw1_q   <= switch;
            sw2_q   <= sw1_q;
            rdata_q <= rdata_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign io_rdata = rdata_q;
    assign Led      = led_q;
    assign AN       = an_q;
    assign Seg      = seg_q;

endmodule

// File: tb/tb_mmio_display_port.sv
// Directed bench for mmio_display_port: load results go through a
// scoreboard queue; display and LED checks use a frame-position model.
module tb_mmio_display_port;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_ = 1'b0;
    logic [7:0]  io_addr = '0;
    logic        io_write = 1'b0;
    logic        io_read = 1'b0;
    logic [1:0]  siz = '0;
    logic        SE_s = 1'b0;
    logic [31:0] io_wdata = '0;
    logic [31:0] io_rdata;
    logic [2:0]  switch = '0;
    logic [16:0] Led;
    logic [7:0]  AN;
    logic [7:0]  Seg;

    int n_chk = 0;
    int n_fail = 0;
    int cyc;
    logic rd_pend;
    logic [31:0] exp_q[$];

    logic [31:0] sh_disp = '0;
    logic [7:0]  sh_en = 8'hFF;
    logic [7:0]  sh_dp = 8'h00;
    logic [6:0]  font [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                               7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C,
                               7'h39, 7'h5E, 7'h79, 7'h71};

    mmio_display_port #(.SCAN_DIV(DIV)) dut (
        .clk(clk), .rst_(rst_), .io_addr(io_addr),
        .io_write(io_write), .io_read(io_read), .siz(siz),
        .SE_s(SE_s), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .switch(switch), .Led(Led), .AN(AN), .Seg(Seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            cyc <= 0;
            rd_pend <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            rd_pend <= io_read;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one result per load, the cycle after io_read.
    always @(negedge clk) begin
        if (rst_ && rd_pend) begin
            if (exp_q.size() == 0)
                chk("unexpected_load", io_rdata, 32'hXXXX_XXXX);
            else
                chk("load_data", io_rdata, exp_q.pop_front());
        end
    end

    task automatic wr(input logic [7:0] a, input logic [1:0] s,
                      input logic [31:0] d);
        io_addr = a; siz = s; io_wdata = d; io_write = 1'b1;
        @(negedge clk);
        io_write = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [1:0] s,
                      input logic se, input logic [31:0] e);
        exp_q.push_back(e);
        io_addr = a; siz = s; SE_s = se; io_read = 1'b1;
        @(negedge clk);
        io_read = 1'b0;
    endtask

    task automatic wait_slot(input int k, input string name);
        int i;
        logic [7:0] ea, es;
        repeat (2) @(negedge clk);
        for (i = 0; i < 64; i++) begin
            if (cyc >= 1 && ((cyc - 1) / DIV) % 8 == k) break;
            @(negedge clk);
        end
        if (i == 64) begin
            chk({name, "_timeout"}, 32'd1, 32'd0);
        end else begin
            ea = sh_en[k] ? ~(8'd1 << k) : 8'hFF;
            es = sh_en[k] ? ~{sh_dp[k], font[sh_disp[4*k +: 4]]} : 8'hFF;
            chk({name, "_AN"}, {24'd0, AN}, {24'd0, ea});
            chk({name, "_Seg"}, {24'd0, Seg}, {24'd0, es});
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_AN", {24'd0, AN}, 32'hFE);
        chk("rst_Seg", {24'd0, Seg}, 32'hC0);
        chk("rst_rdata", io_rdata, 32'd0);
        chk("rst_Led", {15'd0, Led}, 32'd0);
        rst_ = 1'b1;

        for (int n = 1; n <= 33; n++) begin
            @(negedge clk);
            if (n == 4)  chk("dwell_end_AN", {24'd0, AN}, 32'hFE);
            if (n == 5)  chk("digit1_AN", {24'd0, AN}, 32'hFD);
            if (n == 5)  chk("digit1_Seg", {24'd0, Seg}, 32'hC0);
            if (n == 32) chk("digit7_AN", {24'd0, AN}, 32'h7F);
            if (n == 33) chk("frame_wrap_AN", {24'd0, AN}, 32'hFE);
        end

        wr(8'h04, 2'd2, 32'h89AB_CDEF);
        sh_disp = 32'h89AB_CDEF;
        wait_slot(0, "d0");
        chk("d0_Seg_const", {24'd0, Seg}, 32'h8E);
        wait_slot(7, "d7");
        chk("d7_Seg_const", {24'd0, Seg}, 32'h80);
        wait_slot(3, "d3");
        chk("d3_Seg_const", {24'd0, Seg}, 32'hC6);
        wait_slot(5, "d5");
        chk("d5_Seg_const", {24'd0, Seg}, 32'h88);

        wr(8'h02, 2'd0, 32'h0000_00FF);
        chk("led_byte2", {15'd0, Led}, 32'h0001_0000);
        wr(8'h00, 2'd2, 32'h0001_2345);
        chk("led_word", {15'd0, Led}, 32'h0001_2345);
        rd(8'h01, 2'd0, 1'b1, 32'h0000_0023);
        rd(8'h02, 2'd1, 1'b1, 32'h0000_0001);
        rd(8'h04, 2'd0, 1'b1, 32'hFFFF_FFEF);
        rd(8'h04, 2'd0, 1'b0, 32'h0000_00EF);
        rd(8'h06, 2'd1, 1'b1, 32'hFFFF_89AB);
        rd(8'h05, 2'd1, 1'b0, 32'h0000_CDEF);
        rd(8'h07, 2'd0, 1'b1, 32'hFFFF_FF89);
        rd(8'h04, 2'd3, 1'b1, 32'h89AB_CDEF);
        wr(8'h01, 2'd1, 32'h5555_ABCD);
        chk("led_half", {15'd0, Led}, 32'h0001_ABCD);
        rd(8'h03, 2'd2, 1'b0, 32'h0001_ABCD);

        wr(8'h08, 2'd2, 32'h0000_01FE);
        sh_en = 8'hFE; sh_dp = 8'h01;
        wait_slot(0, "blank0");
        wait_slot(1, "ctrl1_d1");
        wr(8'h08, 2'd2, 32'h0000_0202);
        sh_en = 8'h02; sh_dp = 8'h02;
        wait_slot(1, "dp_d1");
        chk("dp_d1_const", {24'd0, Seg}, 32'h06);
        wait_slot(2, "blank2");
        rd(8'h08, 2'd2, 1'b0, 32'h0000_0202);
        rd(8'h09, 2'd0, 1'b0, 32'h0000_0002);

        switch = 3'b101;
        rd(8'h0C, 2'd2, 1'b0, 32'd0);
        rd(8'h0C, 2'd2, 1'b0, 32'd0);
        rd(8'h0C, 2'd2, 1'b0, 32'd5);
        wr(8'h0C, 2'd2, 32'hFFFF_FFFF);
        wr(8'h20, 2'd2, 32'hFFFF_FFFF);
        rd(8'h0C, 2'd2, 1'b0, 32'd5);
        rd(8'h20, 2'd2, 1'b0, 32'd0);
        rd(8'h00, 2'd2, 1'b0, 32'h0001_ABCD);
        rd(8'h04, 2'd2, 1'b0, 32'h89AB_CDEF);
        rd(8'h08, 2'd2, 1'b0, 32'h0000_0202);

        exp_q.push_back(32'h0001_ABCD);
        io_addr = 8'h00; siz = 2'd2; io_wdata = 32'h0000_0055;
        io_read = 1'b1; io_write = 1'b1;
        @(negedge clk);
        io_read = 1'b0; io_write = 1'b0;
        chk("rw_led", {15'd0, Led}, 32'h0000_0055);

        wr(8'h08, 2'd2, 32'h0000_00FF);
        repeat (7) @(negedge clk);
        io_addr = 8'h04; siz = 2'd2; io_read = 1'b1;
        #2 rst_ = 1'b0;
        #1;
        chk("async_AN", {24'd0, AN}, 32'hFE);
        chk("async_Seg", {24'd0, Seg}, 32'hC0);
        chk("async_Led", {15'd0, Led}, 32'd0);
        chk("async_rdata", io_rdata, 32'd0);
        @(posedge clk);
        #1;
        io_read = 1'b0;
        chk("rst_no_load", io_rdata, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
